// File: rtl/pll_pkg.sv
// Types shared between the droop detector and the PLL droop manager,
// plus small byte helpers used by the detector.
package pll_pkg;

  typedef enum logic [1:0] {
    BRAKES_OFF = 2'd0,
    BRAKING    = 2'd1,
    RECOVERING = 2'd2
  } brake_state_t;

  typedef enum logic [1:0] {
    MONITOR = 2'd0,
    TRIPPED = 2'd1,
    HOLDOFF = 2'd2
  } droop_state_t;

  function automatic logic [7:0] min8(input logic [7:0] a, input logic [7:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [7:0] max8(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sample_debounce.sv
// Saturating consecutive-event counter. done reflects the count as it will be
// after the current edge, so a caller can act on the edge that completes a run.
module sample_debounce #(
  parameter int W     = 4,
  parameter int LIMIT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic done
);

  localparam logic [W-1:0] LIM = W'(LIMIT);

  logic [W-1:0] count;
  logic [W-1:0] count_next;

  always_comb begin
    count_next = count;
    if (clr) begin
      count_next = '0;
    end else if (inc && (count < LIM)) begin
      count_next = count + 1'b1;
    end
  end

  assign done = (count_next >= LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/droop_detect.sv
// Supply droop detector: debounces low supply samples into a registered brake
// request, holds it for a minimum time and until the supply recovers.
module droop_detect
  import pll_pkg::*;
#(
  parameter int TRIP_SAMPLES     = 2,
  parameter int CLEAR_SAMPLES    = 8,
  parameter int MIN_BRAKE_CYCLES = 16
) (
  input  logic         refclk,
  input  logic         resetn,
  input  logic         enable,
  input  logic [7:0]   vsense,
  input  logic [7:0]   thresh_trip,
  input  logic [7:0]   thresh_clear,
  input  brake_state_t brake_state,
  output logic         brake,
  output logic [15:0]  trip_count,
  output logic [7:0]   min_vsense,
  output droop_state_t state
);

  localparam logic [15:0] HOLD_MIN = 16'(MIN_BRAKE_CYCLES);

  droop_state_t state_next;
  logic [7:0]   high_level;
  logic         is_low;
  logic         is_high;
  logic         arm;
  logic         trip_inc;
  logic         trip_done;
  logic         trip_fire;
  logic         clr_inc;
  logic         clear_done;
  logic         release_ok;
  logic [15:0]  hold_cnt;

  // A clear threshold below the trip threshold collapses the hysteresis band.
  assign high_level = max8(thresh_clear, thresh_trip);
  assign is_low     = (vsense < thresh_trip);
  assign is_high    = (vsense >= high_level);

  assign arm = ((state == MONITOR) && enable) ||
               ((state == HOLDOFF) && (brake_state == BRAKING));

  assign trip_inc  = arm && is_low;
  assign trip_fire = trip_inc && trip_done;
  assign clr_inc   = (state == TRIPPED) && is_high;

  sample_debounce #(
    .W     (4),
    .LIMIT (TRIP_SAMPLES)
  ) u_trip (
    .clk   (refclk),
    .rst_n (resetn),
    .inc   (trip_inc),
    .clr   (!trip_inc),
    .done  (trip_done)
  );

  sample_debounce #(
    .W     (8),
    .LIMIT (CLEAR_SAMPLES)
  ) u_clear (
    .clk   (refclk),
    .rst_n (resetn),
    .inc   (clr_inc),
    .clr   (!clr_inc),
    .done  (clear_done)
  );

  // hold_cnt equals the brake-high cycles completed at the current edge.
  assign release_ok = (state == TRIPPED) && (hold_cnt >= HOLD_MIN) && clear_done;

  always_comb begin
    state_next = state;
    case (state)
      MONITOR: begin
        if (trip_fire) state_next = TRIPPED;
      end
      TRIPPED: begin
        if (release_ok) state_next = HOLDOFF;
      end
      HOLDOFF: begin
        if (brake_state == BRAKES_OFF) begin
          state_next = MONITOR;
        end else if (trip_fire) begin
          state_next = TRIPPED;
        end
      end
      default: state_next = MONITOR;
    endcase
  end

  always_ff @(posedge refclk or negedge resetn) begin
    if (!resetn) begin
      state <= MONITOR;
      brake <= 1'b0;
    end else begin
      state <= state_next;
      brake <= (state_next == TRIPPED);
    end
  end

  always_ff @(posedge refclk or negedge resetn) begin
    if (!resetn) begin
      hold_cnt   <= '0;
      trip_count <= '0;
      min_vsense <= 8'hFF;
    end else if (trip_fire) begin
      hold_cnt   <= 16'd1;
      min_vsense <= vsense;
      if (trip_count != 16'hFFFF) trip_count <= trip_count + 16'd1;
    end else if (state == TRIPPED) begin
      if (hold_cnt < HOLD_MIN) hold_cnt <= hold_cnt + 16'd1;
      min_vsense <= min8(min_vsense, vsense);
    end else begin
      hold_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_droop_detect.sv
// Directed bench for droop_detect with default parameters: a vector table for
// the basic trip/release flow plus hand sequences for the multi-cycle cases.
module tb_droop_detect;
  import pll_pkg::*;

  logic         refclk;
  logic         resetn;
  logic         enable;
  logic [7:0]   vsense;
  logic [7:0]   thresh_trip;
  logic [7:0]   thresh_clear;
  brake_state_t brake_state;
  logic         brake;
  logic [15:0]  trip_count;
  logic [7:0]   min_vsense;
  droop_state_t state;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic         en;
    logic [7:0]   vs;
    brake_state_t bs;
    logic         exp_brake;
    logic [15:0]  exp_cnt;
    logic [7:0]   exp_min;
    droop_state_t exp_state;
  } vec_t;

  vec_t tbl[$];

  droop_detect #(
    .TRIP_SAMPLES     (2),
    .CLEAR_SAMPLES    (8),
    .MIN_BRAKE_CYCLES (16)
  ) dut (
    .refclk       (refclk),
    .resetn       (resetn),
    .enable       (enable),
    .vsense       (vsense),
    .thresh_trip  (thresh_trip),
    .thresh_clear (thresh_clear),
    .brake_state  (brake_state),
    .brake        (brake),
    .trip_count   (trip_count),
    .min_vsense   (min_vsense),
    .state        (state)
  );

  // clock / reset
  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic eb, input logic [15:0] ec,
                         input logic [7:0] em, input droop_state_t es);
    chk({tag, " brake"}, 32'(brake), 32'(eb));
    chk({tag, " trip_count"}, 32'(trip_count), 32'(ec));
    chk({tag, " min_vsense"}, 32'(min_vsense), 32'(em));
    chk({tag, " state"}, 32'(state), 32'(es));
  endtask

  task automatic do_reset(input logic [7:0] tclear);
    resetn       = 1'b0;
    enable       = 1'b1;
    vsense       = 8'd120;
    thresh_trip  = 8'd100;
    thresh_clear = tclear;
    brake_state  = BRAKES_OFF;
    repeat (3) tick();
    chk_all("reset", 1'b0, 16'd0, 8'hFF, MONITOR);
    resetn = 1'b1;
  endtask

  function automatic void add(input logic en, input logic [7:0] vs, input brake_state_t bs,
                              input logic eb, input logic [15:0] ec, input logic [7:0] em,
                              input droop_state_t es);
    vec_t v;
    v.en = en; v.vs = vs; v.bs = bs;
    v.exp_brake = eb; v.exp_cnt = ec; v.exp_min = em; v.exp_state = es;
    tbl.push_back(v);
  endfunction

  initial begin
    // single low, in-band sample, then a two-sample trip held 16 cycles
    add(1, 8'd120, BRAKES_OFF, 0, 0, 8'hFF, MONITOR);
    add(1, 8'd90,  BRAKES_OFF, 0, 0, 8'hFF, MONITOR);
    add(1, 8'd120, BRAKES_OFF, 0, 0, 8'hFF, MONITOR);
    add(1, 8'd90,  BRAKES_OFF, 0, 0, 8'hFF, MONITOR);
    add(1, 8'd105, BRAKES_OFF, 0, 0, 8'hFF, MONITOR);
    add(1, 8'd90,  BRAKES_OFF, 0, 0, 8'hFF, MONITOR);
    add(1, 8'd85,  BRAKES_OFF, 1, 1, 8'd85, TRIPPED);
    for (int i = 0; i < 15; i++) add(1, 8'd120, BRAKES_OFF, 1, 1, 8'd85, TRIPPED);
    add(1, 8'd120, BRAKES_OFF, 0, 1, 8'd85, HOLDOFF);
    // return to MONITOR wins over a low sample; trip counting restarts from zero
    add(1, 8'd80,  BRAKES_OFF, 0, 1, 8'd85, MONITOR);
    add(1, 8'd80,  BRAKES_OFF, 0, 1, 8'd85, MONITOR);
    add(1, 8'd120, BRAKES_OFF, 0, 1, 8'd85, MONITOR);
    // enable gates new trips
    add(0, 8'd80,  BRAKES_OFF, 0, 1, 8'd85, MONITOR);
    add(0, 8'd80,  BRAKES_OFF, 0, 1, 8'd85, MONITOR);
    add(1, 8'd80,  BRAKES_OFF, 0, 1, 8'd85, MONITOR);
    add(1, 8'd120, BRAKES_OFF, 0, 1, 8'd85, MONITOR);

    // steady healthy supply
    do_reset(8'd110);
    vsense = 8'd120;
    for (int i = 0; i < 1000; i++) begin
      tick();
      chk($sformatf("steady[%0d] brake", i), 32'(brake), 32'd0);
    end
    chk("steady trip_count", 32'(trip_count), 32'd0);
    chk("steady min_vsense", 32'(min_vsense), 32'hFF);

    // vector table
    do_reset(8'd110);
    for (int i = 0; i < tbl.size(); i++) begin
      enable      = tbl[i].en;
      vsense      = tbl[i].vs;
      brake_state = tbl[i].bs;
      tick();
      chk_all($sformatf("tbl[%0d]", i), tbl[i].exp_brake, tbl[i].exp_cnt,
              tbl[i].exp_min, tbl[i].exp_state);
    end

    // in-band samples keep the brake on; release 8 samples after recovery
    do_reset(8'd110);
    vsense = 8'd90;  tick();
    vsense = 8'd85;  tick();
    chk_all("band trip", 1'b1, 16'd1, 8'd85, TRIPPED);
    vsense = 8'd105;
    for (int i = 0; i < 40; i++) begin
      tick();
      chk($sformatf("band[%0d] brake", i), 32'(brake), 32'd1);
    end
    vsense = 8'd120;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("band rel[%0d] brake", k), 32'(brake), 32'(k < 8));
    end
    chk_all("band holdoff", 1'b0, 16'd1, 8'd85, HOLDOFF);
    tick();
    chk_all("band monitor", 1'b0, 16'd1, 8'd85, MONITOR);

    // RECOVERING ignores lows, BRAKING re-trips even with enable low
    do_reset(8'd110);
    brake_state = RECOVERING;
    vsense = 8'd90; tick();
    vsense = 8'd90; tick();
    chk_all("rec trip", 1'b1, 16'd1, 8'd90, TRIPPED);
    enable = 1'b0;
    vsense = 8'd120;
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk($sformatf("rec hold[%0d] brake", k), 32'(brake), 32'(k < 16));
    end
    chk("rec release state", 32'(state), 32'(HOLDOFF));
    vsense = 8'd90;
    for (int i = 0; i < 50; i++) begin
      tick();
      chk($sformatf("rec low[%0d] brake", i), 32'(brake), 32'd0);
    end
    chk("rec low state", 32'(state), 32'(HOLDOFF));
    brake_state = BRAKING;
    tick();
    chk_all("braking first low", 1'b0, 16'd1, 8'd90, HOLDOFF);
    tick();
    chk_all("braking retrip", 1'b1, 16'd2, 8'd90, TRIPPED);

    // asynchronous reset inside TRIPPED, then release with a collapsed band
    do_reset(8'd50);
    vsense = 8'd90; tick();
    vsense = 8'd85; tick();
    chk_all("async trip", 1'b1, 16'd1, 8'd85, TRIPPED);
    vsense = 8'd120;
    repeat (5) tick();
    chk("async pre brake", 32'(brake), 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk_all("async mid-cycle", 1'b0, 16'd0, 8'hFF, MONITOR);
    tick();
    tick();
    resetn = 1'b1;
    vsense = 8'd90; tick();
    chk("post-reset single low brake", 32'(brake), 32'd0);
    tick();
    chk_all("post-reset trip", 1'b1, 16'd1, 8'd90, TRIPPED);
    vsense = 8'd100;
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk($sformatf("low clear[%0d] brake", k), 32'(brake), 32'(k < 16));
    end
    chk("low clear state", 32'(state), 32'(HOLDOFF));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/droop_detect.md
DROOP_DETECT -- requirements
Module: droop_detect

Interface
REQ-001 Parameter TRIP_SAMPLES, default 2: consecutive low samples required to trip (legal 1..15).
REQ-002 Parameter CLEAR_SAMPLES, default 8: consecutive high samples required to release (legal 1..255).
REQ-003 Parameter MIN_BRAKE_CYCLES, default 16: minimum refclk cycles brake stays high (legal 1..65535).
REQ-004 refclk  input  1  sole clock; all state updates on its rising edge.
REQ-005 resetn  input  1  asynchronous, active-low reset.
REQ-006 enable  input  1  gates new trips only.
REQ-007 vsense  input  8  unsigned supply-monitor sample, valid every refclk cycle.
REQ-008 thresh_trip  input  8  unsigned; a sample is low when vsense < thresh_trip.
REQ-009 thresh_clear  input  8  unsigned; a sample is high when vsense >= max(thresh_clear, thresh_trip).
REQ-010 brake_state  input  brake_state_t  recovery status returned by the PLL droop manager.
REQ-011 brake  output  1  registered brake request to the PLL.
REQ-012 trip_count  output  16  saturating count of trips.
REQ-013 min_vsense  output  8  lowest vsense sampled during the current or last TRIPPED episode.

Function
REQ-014 The FSM shall have exactly three states: MONITOR, TRIPPED and HOLDOFF; brake = 1 only in TRIPPED.
REQ-015 In MONITOR with enable=1, each low sample increments trip_cnt; any other sample, or enable=0, clears it to 0.
REQ-016 On the edge that samples the TRIP_SAMPLES-th consecutive low sample, the FSM enters TRIPPED; brake is high immediately after that edge (zero added latency).
REQ-017 On TRIPPED entry: hold_cnt <= 1; clear_cnt <= 0; min_vsense <= current vsense; trip_count <= trip_count+1, saturating at 0xFFFF.
REQ-018 In TRIPPED:
- hold_cnt increments, saturating at MIN_BRAKE_CYCLES.
- clear_cnt increments on a high sample, saturating at CLEAR_SAMPLES, and clears on any other sample.
- min_vsense <= min(min_vsense, vsense).
REQ-019 TRIPPED exits to HOLDOFF on the edge where hold_cnt >= MIN_BRAKE_CYCLES and clear_cnt >= CLEAR_SAMPLES, both evaluated after that edge's updates; brake is 0 after that edge.
REQ-020 Samples between the two thresholds are neither low nor high: they clear clear_cnt and never trip (hysteresis).
REQ-021 In HOLDOFF, the FSM returns to MONITOR, with trip_cnt = 0, on the first edge where brake_state == BRAKES_OFF.
REQ-022 In HOLDOFF with brake_state == BRAKING, the trip rule of REQ-015/016 applies, regardless of enable, and a trip re-enters TRIPPED.
REQ-023 In HOLDOFF with brake_state == RECOVERING, low samples are ignored and trip_cnt is held at 0.
REQ-024 In TRIPPED and HOLDOFF, enable is ignored; a brake in progress always completes.
REQ-025 If a BRAKES_OFF return and a trip condition occur on the same edge in HOLDOFF, BRAKES_OFF takes priority and the FSM goes to MONITOR.
REQ-026 trip_count shall never wrap.

Reset
REQ-027 While resetn = 0: state = MONITOR, brake = 0, trip_cnt = clear_cnt = hold_cnt = 0, trip_count = 0, min_vsense = 0xFF.
REQ-028 Assertion mid-operation, including in TRIPPED, drops brake asynchronously.
REQ-029 The first trip after deassertion requires a full TRIP_SAMPLES sequence.

Structure
REQ-030 brake_state_t (BRAKES_OFF, BRAKING, RECOVERING) and droop_state_t (MONITOR, TRIPPED, HOLDOFF) shall live in the shared pll_pkg package, imported by both this block and the PLL.
REQ-031 One sub-module, sample_debounce, shall be used: a parameterised saturating consecutive-event counter with clear and done outputs, instantiated twice (trip and clear).
REQ-032 Implementation shall be 120-400 lines of RTL with no latches and no combinational path from vsense to brake.

Verification (TRIP_SAMPLES=2, CLEAR_SAMPLES=8, MIN_BRAKE_CYCLES=16, thresh_trip=100, thresh_clear=110, brake_state=BRAKES_OFF unless stated)
REQ-033 vsense=120 for 1000 cycles -> brake = 0 throughout, trip_count = 0, min_vsense = 0xFF.
REQ-034 vsense 120, single sample 90, then 120 -> no trip; samples 90, 85, then 120 -> brake high after the second low edge for exactly 16 cycles, trip_count = 1, min_vsense = 85.
REQ-035 Trip, then vsense=105 for 40 cycles, then 120 -> brake stays high until 8 cycles after vsense reaches 120.
REQ-036 Release with brake_state=RECOVERING and vsense=90 for 50 cycles -> brake stays 0; then brake_state=BRAKING with two samples of 90 -> re-trip, trip_count = 2.
REQ-037 resetn pulsed low 5 cycles into TRIPPED -> brake falls without a clock edge and all outputs take their reset values; thresh_clear=50 -> release occurs at vsense >= 100.
